// File: rtl/y86_pkg.sv
// y86_pkg: shared ALU opcodes and datapath width for the Y86 SEQ execute stage
package y86_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  localparam int WORD_W = 64;
endpackage

// File: rtl/alu_full_adder.sv
// alu_full_adder: single-bit full adder cell for the ripple adder
module alu_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/alu_block.sv
// alu_block: registered 64-bit add/sub/and/xor ALU with carry-out in bit 64
module alu_block
  import y86_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   Ain,
  input  logic [WORD_W-1:0]   Bin,
  input  logic                S0,
  input  logic                S1,
  output logic [WORD_W:0]     Final_Output
);
  logic [1:0]        op;
  logic [WORD_W:0]   c;
  logic [WORD_W-1:0] b_x;
  logic [WORD_W-1:0] sum;
  logic [WORD_W:0]   res;
  assign op   = {S1, S0};
  // S0 turns the adder into Ain + ~Bin + 1 for subtraction
  assign b_x  = Bin ^ {WORD_W{S0}};
  assign c[0] = S0;
  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    alu_full_adder u_fa (
      .a   (Ain[i]),
      .b   (b_x[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end
  always_comb begin
    res = (op == ALU_AND) ? {1'b0, Ain & Bin} :
          (op == ALU_XOR) ? {1'b0, Ain ^ Bin} :
                            {c[WORD_W], sum};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Final_Output <= '0;
    else        Final_Output <= res;
  end
endmodule

// File: tb/tb_alu_block.sv
// tb_alu_block: vector table, corner sequences and randomized model check for alu_block
module tb_alu_block;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        s0 = 1'b0;
  logic        s1 = 1'b0;
  logic [64:0] out;
  int total = 0;
  int bad = 0;

  alu_block dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Ain         (a),
    .Bin         (b),
    .S0          (s0),
    .S1          (s1),
    .Final_Output(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [64:0] model(logic [1:0] op, logic [63:0] x, logic [63:0] y);
    case (op)
      2'b00: model = {1'b0, x} + {1'b0, y};
      2'b01: model = {(x >= y), x - y};
      2'b10: model = {1'b0, x & y};
      default: model = {1'b0, x ^ y};
    endcase
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
    {s1, s0} = op;
    a = x;
    b = y;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 64'h7FFF_FFFF_FFFF_FFFF;
      1: pick = 64'h8000_0000_0000_0000;
      2: pick = 64'hFFFF_FFFF_FFFF_FFFF;
      3: pick = 64'd0;
      4: pick = 64'd1;
      default: pick = {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [64:0] exp_q;
    logic [64:0] seq_exp[4];
    tbl[0] = '{"add_wrap",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000};
    tbl[1] = '{"add_neg",   2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 65'h1_0000_0000_0000_0007};
    tbl[2] = '{"add_maxp",  2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65'h0_8000_0000_0000_0000};
    tbl[3] = '{"sub_pos",   2'b01, 64'd100, 64'd64, 65'h1_0000_0000_0000_0024};
    tbl[4] = '{"sub_borrow",2'b01, 64'd0, 64'd1, 65'h0_FFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{"sub_minneg",2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000};
    tbl[6] = '{"and",       2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 65'h0_F000_F000_F000_F000};
    tbl[7] = '{"xor",       2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 65'h0_0FF0_0FF0_0FF0_0FF0};
    tbl[8] = '{"and_ones",  2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h0_FFFF_FFFF_FFFF_FFFF};
    tbl[9] = '{"xor_self",  2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 65'h0};
    seq_exp = '{65'd5, 65'h0_FFFF_FFFF_FFFF_FFFF, 65'd2, 65'd5};

    // reset behaviour
    drive(2'b00, 64'd9, 64'd9);
    @(negedge clk);
    chk("reset_state", out, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pre_reset_add", out, 65'd18);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", out, 65'd0);
    @(posedge clk);
    #1 chk("reset_held", out, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 64'd5, 64'd7);
    @(negedge clk);
    chk("add_5_7", out, 65'd12);

    // vector table
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      @(negedge clk);
      chk(tbl[i].name, out, tbl[i].exp);
    end

    // back-to-back op changes, checking one-cycle latency
    drive(2'b00, 64'd2, 64'd3);
    #4 chk("b2b_hold0", out, tbl[9].exp);
    @(negedge clk);
    chk("b2b_add", out, seq_exp[0]);
    drive(2'b01, 64'd2, 64'd3);
    #4 chk("b2b_hold1", out, seq_exp[0]);
    @(negedge clk);
    chk("b2b_sub", out, seq_exp[1]);
    drive(2'b10, 64'd6, 64'd3);
    #4 chk("b2b_hold2", out, seq_exp[1]);
    @(negedge clk);
    chk("b2b_and", out, seq_exp[2]);
    drive(2'b11, 64'd6, 64'd3);
    #4 chk("b2b_hold3", out, seq_exp[2]);
    @(negedge clk);
    chk("b2b_xor", out, seq_exp[3]);

    // randomized against the model
    for (int i = 0; i < 10000; i++) begin
      logic [1:0]  op;
      logic [63:0] x, y;
      op = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      drive(op, x, y);
      exp_q = model(op, x, y);
      @(negedge clk);
      chk("random", out, exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
